// File: rtl/accel_pkg.sv
// Shared constants and types for the accelerator output paths.
// Array geometry, state encoding, saturation limits and the row-major index.
package accel_pkg;

  localparam int N      = 8;
  localparam int PSUM_W = 24;
  localparam int OUT_W  = 8;
  localparam int NN     = N * N;
  localparam int IDX_W  = $clog2(NN);
  localparam int RC_W   = $clog2(N);

  localparam int OUT_MAX = (2 ** (OUT_W - 1)) - 1;
  localparam int OUT_MIN = -(2 ** (OUT_W - 1));

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } drain_state_e;

  function automatic int rm_index(input int row, input int col);
    return row * N + col;
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Requantizer: arithmetic right shift (floor) then signed saturation to OUT_W.
// Purely combinational so it can sit directly behind a register bank.
module requant_sat
  import accel_pkg::*;
(
  input  logic [PSUM_W-1:0] din,
  input  logic [4:0]        shift,
  output logic [OUT_W-1:0]  dout
);

  localparam logic signed [PSUM_W-1:0] HI = PSUM_W'(OUT_MAX);
  localparam logic signed [PSUM_W-1:0] LO = PSUM_W'(OUT_MIN);

  logic signed [PSUM_W-1:0] y;

  always_comb begin
    y = $signed(din) >>> shift;
    if (y > HI) begin
      dout = OUT_W'(OUT_MAX);
    end else if (y < LO) begin
      dout = OUT_W'(OUT_MIN);
    end else begin
      dout = y[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/result_drain.sv
// Snapshots the systolic array's partial sums and streams them out row-major,
// requantized, over a valid/ready handshake.
//
//   state     | meaning
//   ST_IDLE   | no snapshot held; waiting for capture
//   ST_STREAM | snapshot held; presenting bank[idx] until the last handshake
module result_drain
  import accel_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture,
  input  logic [NN*PSUM_W-1:0]   result_flat,
  input  logic [4:0]             shift,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic [RC_W-1:0]        out_row,
  output logic [RC_W-1:0]        out_col,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(rm_index(N - 1, N - 1));
  localparam logic [4:0]       SHIFT_MAX = 5'(PSUM_W - 1);

  drain_state_e            state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4:0]              shift_q, shift_d;
  logic                    done_q, done_d;
  logic                    load;
  logic [PSUM_W-1:0]       bank_q [NN];
  logic [OUT_W-1:0]        rq_data;
  logic                    streaming;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          load    = 1'b1;
          state_d = ST_STREAM;
          idx_d   = '0;
          shift_d = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  // Bank content is don't-care after reset, so it carries no reset term.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NN; i++) begin
        bank_q[i] <= result_flat[i*PSUM_W +: PSUM_W];
      end
    end
  end

  requant_sat u_requant_sat (
    .din   (bank_q[idx_q]),
    .shift (shift_q),
    .dout  (rq_data)
  );

  assign streaming = (state_q == ST_STREAM);
  assign out_valid = streaming;
  assign busy      = streaming;
  assign done      = done_q;
  assign out_data  = streaming ? rq_data : '0;
  assign out_row   = streaming ? idx_q[IDX_W-1:RC_W] : '0;
  assign out_col   = streaming ? idx_q[RC_W-1:0] : '0;
  assign out_last  = streaming && (idx_q == LAST_IDX);

endmodule
